rc4_stream_encryptor: RTL

Byte-serial RC4 encryptor: the transmit-side counterpart of the RC4 decrypt controller. On `start`, it runs the RC4 PRGA over an externally initialised S-box RAM, already loaded by the KSA stage. It accepts plaintext bytes over a valid/ready handshake, XORs each with the keystream byte and writes the result to the ciphertext RAM at address k. It sits between the KSA controller/S RAM and the ciphertext RAM, and its output memory image is the input image the decryptor consumes.

---
 rtl/rc4_stream_encryptor.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/rc4_stream_encryptor.sv
// rc4_stream_encryptor: byte-serial RC4 PRGA over an external S RAM,
// XORs keystream with handshaked plaintext. Option: RC4_PT_CHECK_EN.
module rc4_stream_encryptor #(
    parameter int MSG_LEN = 32
) (
    input  logic       clk,
    input  logic       reset_task,
    input  logic       start,
    input  logic [7:0] pt_data,
    input  logic       pt_valid,
    output logic       pt_ready,
    output logic [7:0] address_s,
    output logic [7:0] data_s,
    output logic       wren_s,
    input  logic [7:0] q_s,
    output logic [7:0] address_e,
    output logic [7:0] data_e,
    output logic       wren_e,
    output logic       done_enc,
    output logic       pt_error
);

    localparam logic [7:0] LAST = 8'(MSG_LEN - 1);

    typedef enum logic [4:0] {
        IDLE, INC_I,
        GET_SI, WAIT_SI, STORE_SI, UPD_J,
        GET_SJ, WAIT_SJ, STORE_SJ,
        WR_J, WR_I, SUM,
        GET_F, WAIT_F, STORE_F,
        WAIT_PT, CHECK, WR_CT, INC_K,
        DONE, ERROR
    } state_t;

    state_t state, state_n;

    logic [7:0] i, j, k, si, sj, sum, f, pt;

    // state register
    always_ff @(posedge clk) begin
        if (reset_task) state <= IDLE;
        else            state <= state_n;
    end

    // datapath registers, each updated only in its own state
    always_ff @(posedge clk) begin
        if (reset_task) begin
            i   <= 8'd0;
            j   <= 8'd0;
            k   <= 8'd0;
            si  <= 8'd0;
            sj  <= 8'd0;
            sum <= 8'd0;
            f   <= 8'd0;
            pt  <= 8'd0;
        end else begin
            case (state)
                INC_I:    i   <= i + 8'd1;
                STORE_SI: si  <= q_s;
                UPD_J:    j   <= j + si;
                STORE_SJ: sj  <= q_s;
                SUM:      sum <= si + sj;
                STORE_F:  f   <= q_s;
                WAIT_PT:  if (pt_valid) pt <= pt_data;
                INC_K:    if (k != LAST) k <= k + 8'd1;
                default: ;
            endcase
        end
    end

`ifdef RC4_PT_CHECK_EN
    logic pt_legal;
    assign pt_legal = (pt == 8'h20) ||
                      (pt >= 8'h61 && pt <= 8'h7a);
`endif

    // next-state sequencing
    always_comb begin
        state_n = state;
        case (state)
            IDLE:     if (start) state_n = INC_I;
            INC_I:    state_n = GET_SI;
            GET_SI:   state_n = WAIT_SI;
            WAIT_SI:  state_n = STORE_SI;
            STORE_SI: state_n = UPD_J;
            UPD_J:    state_n = GET_SJ;
            GET_SJ:   state_n = WAIT_SJ;
            WAIT_SJ:  state_n = STORE_SJ;
            STORE_SJ: state_n = WR_J;
            WR_J:     state_n = WR_I;
            WR_I:     state_n = SUM;
            SUM:      state_n = GET_F;
            GET_F:    state_n = WAIT_F;
            WAIT_F:   state_n = STORE_F;
            STORE_F:  state_n = WAIT_PT;
`ifdef RC4_PT_CHECK_EN
            WAIT_PT:  if (pt_valid) state_n = CHECK;
            CHECK:    state_n = pt_legal ? WR_CT : ERROR;
            ERROR:    state_n = ERROR;
`else
            WAIT_PT:  if (pt_valid) state_n = WR_CT;
`endif
            WR_CT:    state_n = INC_K;
            INC_K:    state_n = (k == LAST) ? DONE : INC_I;
            DONE:     state_n = DONE;
            default:  state_n = IDLE;
        endcase
    end

    // output decodes of state and registered values
    always_comb begin
        address_s = i;
        data_s    = si;
        wren_s    = 1'b0;
        case (state)
            GET_SJ, WAIT_SJ, STORE_SJ: address_s = j;
            GET_F, WAIT_F, STORE_F:    address_s = sum;
            WR_J: begin
                address_s = j;
                wren_s    = 1'b1;
            end
            WR_I: begin
                data_s = sj;
                wren_s = 1'b1;
            end
            default: ;
        endcase
    end

    assign pt_ready  = (state == WAIT_PT);
    assign wren_e    = (state == WR_CT);
    assign address_e = k;
    assign data_e    = f ^ pt;
    assign done_enc  = (state == DONE);

`ifdef RC4_PT_CHECK_EN
    assign pt_error = (state == ERROR);
`else
    assign pt_error = 1'b0;
`endif

endmodule
